psum_collector: RTL and testbench
=================================

# psum_collector

Output-side collector for the systolic MAC array. It receives the array's bottom-row partial sums: the columns leave the array skewed by one cycle per column, and each column carries its own valid bit. It buffers each column in an independent circular queue and re-aligns them so the downstream consumer (SRAM writeback / accumulator) can pop one full row of `col` psums per read.

## Interface
- `col`, 8, number of array columns / independent column queues
- `psum_bw`, 16, width of one column psum
- `depth`, 64, entries per column queue; power of two, ≥ 2

- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all pointers and flags
- `in`  in  psum_bw*col  column psums; column c at `in[c*psum_bw +: psum_bw]`
- `valid`  in  col  per-column write strobe; `valid[c]` qualifies column c of `in`
- `rd`  in  1  pop one row (one entry from every column)
- `out`  out  psum_bw*col  head entry of every column; column c at `out[c*psum_bw +: psum_bw]`
- `o_valid`  out  1  every column queue non-empty, so a row is available
- `o_full`  out  1  at least one column queue is full
- `o_ready`  out  1  `!o_full`
- `overflow`  out  1  sticky; a write was dropped on a full column

## Operation
- Per column c: `depth`-entry storage, write pointer `wp[c]` and read pointer `rp[c]`. Each pointer is `$clog2(depth)+1` bits; the MSB is a wrap bit.
- Empty_c: `wp[c] == rp[c]`. Full_c: low bits are equal and the wrap bits differ.
- Pointers increment modulo 2^(log2(depth)+1). Storage index is the low `log2(depth)` bits.
- Write: if `valid[c]` is high and (column c is not full, or a pop is accepted in the same cycle), store `in` column c at `wp[c]` and increment `wp[c]`. Columns write independently; any subset of `valid` may be high.
- Dropped write: if `valid[c]` is high, column c is full, and no pop is accepted that cycle, discard the data, leave `wp[c]` unchanged, and set `overflow` to 1. `overflow` clears only on reset.
- Pop: accepted when `rd && o_valid`. On acceptance, every `rp[c]` increments in the same cycle. If `rd` is high while `o_valid` is 0, ignore it: no pointer moves and no flag changes.
- Simultaneous write and pop on the same column: both take effect and the occupancy of that column is unchanged. A write into a full column is legal in the cycle a pop is accepted.
- Output ordering: first-word-fall-through. While `o_valid` is 1, `out` shows storage[`rp[c]`] for every column. While `o_valid` is 0, `out` is forced to all zeros.
- `o_valid` = AND over columns of !Empty_c. `o_full` = OR over columns of Full_c. Both are derived combinationally from the registered pointers.
- Storage is not reset. Only pointers and `overflow` are cleared.

## Timing
- Reset values, in the cycle after `reset` is sampled high: all pointers 0, `o_valid`=0, `o_full`=0, `o_ready`=1, `overflow`=0, `out`=0.
- Reset while operating: reset takes priority over a coincident write or pop in the same cycle. All queued data is discarded.
- Write latency: data written at edge N is visible at `out` (if it is at the head and all columns are non-empty) from edge N onward, i.e. in cycle N+1.
- Skew tolerance: column c may receive its k-th write any number of cycles after column 0's k-th write. `o_valid` rises in the cycle after the last column's first write edge.
- Pop: with `rd` high in cycle N and `o_valid` high, `out` shows the next row after edge N. `o_valid` drops after edge N if any column becomes empty.
- Back-to-back pops are allowed every cycle while `o_valid` stays high.
- `o_full` and `o_ready` update in the cycle after the pointer edge that changes occupancy. No combinational path exists from `valid` or `rd` to any output.

## Test plan
- Reset then idle: `reset` held 2 cycles, then no inputs -> `o_valid`=0, `o_full`=0, `o_ready`=1, `overflow`=0, `out`=0.
- Skewed single row: `col`=8; `valid[c]` high only in cycle c with `in` column c = 100+c -> `o_valid` rises in cycle 8, `out` columns read 100..107, and a single `rd` returns `o_valid` to 0.
- Fill to full: 64 writes to all columns with `rd` low -> `o_full`=1 and `o_ready`=0 after the 64th edge. A 65th write is dropped and `overflow` becomes 1. Popping 64 rows returns the original values 0..63 in order.
- Write and read at full: queue full, then `valid`=all ones with `in` value 999 together with `rd`=1 -> no overflow, `o_full` stays 1, and 999 appears at `out` after 63 further pops.
- Wrap-around: 200 rows streamed with 1 write per cycle and `rd` on every cycle `o_valid` is high, pointers wrapping past 63 -> all 200 rows are read in order and `overflow`=0.
- Ignored read / reset mid-stream: `rd` high while columns 0..6 hold 1 entry and column 7 is empty -> no pointer moves. Then assert `reset` with `valid` and `rd` high -> all flags return to their reset values and no write is retained.

Source files
------------

// File: rtl/psum_collector.sv
// psum_collector: per-column circular queues that re-align skewed
// systolic-array bottom-row psums into full rows for a consumer.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   in, valid    packed column psums and per-column write strobes
//   rd           pop one full row
//   out          head row (zero when no full row is available)
//   o_valid      every column non-empty
//   o_full       some column full
//   o_ready      !o_full
//   overflow     sticky dropped-write flag
module psum_collector #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         valid,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   overflow
);

  localparam int AW = $clog2(depth);

  logic [AW:0]        wp    [col];
  logic [AW:0]        rp    [col];
  logic [psum_bw-1:0] mem   [col][depth];
  logic [col-1:0]     empty;
  logic [col-1:0]     full;
  logic [col-1:0]     wr_en;
  logic [col-1:0]     drop;
  logic               pop;

  always_comb begin
    empty = '0;
    full  = '0;
    for (int c = 0; c < col; c++) begin
      empty[c] = (wp[c] == rp[c]);
      full[c]  = (wp[c][AW-1:0] == rp[c][AW-1:0]) &&
                 (wp[c][AW] != rp[c][AW]);
    end
  end

  assign o_valid = ~|empty;
  assign o_full  = |full;
  assign o_ready = ~o_full;
  assign pop     = rd & o_valid;

  // A pop in the same cycle frees the head slot, so a full
  // column may still accept a write.
  assign wr_en = valid & (~full | {col{pop}});
  assign drop  = valid & full & {col{~pop}};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < col; c++) begin
        wp[c] <= '0;
        rp[c] <= '0;
      end
      overflow <= 1'b0;
    end else begin
      for (int c = 0; c < col; c++) begin
        if (wr_en[c]) wp[c] <= wp[c] + 1'b1;
        if (pop)      rp[c] <= rp[c] + 1'b1;
      end
      if (|drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < col; c++) begin
      if (wr_en[c] && !reset)
        mem[c][wp[c][AW-1:0]] <= in[c*psum_bw +: psum_bw];
    end
  end

  always_comb begin
    out = '0;
    for (int c = 0; c < col; c++) begin
      if (o_valid)
        out[c*psum_bw +: psum_bw] = mem[c][rp[c][AW-1:0]];
    end
  end

endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector: scoreboard bench for psum_collector using a
// per-column queue reference model and randomized traffic.
module tb_psum_collector;

  localparam int COL = 8;
  localparam int PB  = 16;
  localparam int DEP = 64;
  localparam int W   = PB * COL;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   in;
  logic [COL-1:0] valid;
  logic           rd;
  logic [W-1:0]   out;
  logic           o_valid, o_full, o_ready, overflow;

  psum_collector #(.col(COL), .psum_bw(PB), .depth(DEP)) dut (
    .clk(clk), .reset(reset), .in(in), .valid(valid), .rd(rd),
    .out(out), .o_valid(o_valid), .o_full(o_full),
    .o_ready(o_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic         f;
    logic         o;
    logic [W-1:0] row;
  } exp_t;

  exp_t eq[$];
  int   q[COL][$];
  bit   m_ovf;
  bit   known;
  int   checks;
  int   errors;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, req);
    end
  endtask

  // Monitor: one expected status/row per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (eq.size() > 0) begin
      exp_t e;
      e = eq.pop_front();
      chk("o_valid", W'(o_valid), W'(e.v));
      chk("o_full", W'(o_full), W'(e.f));
      chk("o_ready", W'(o_ready), W'(!e.f));
      chk("overflow", W'(overflow), W'(e.o));
      chk("out", out, e.row);
    end
  end

  function automatic bit m_avail();
    for (int c = 0; c < COL; c++)
      if (q[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_full();
    for (int c = 0; c < COL; c++)
      if (q[c].size() == DEP) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input logic [COL-1:0] v, input logic [W-1:0] d,
                      input bit r, input bit rst);
    exp_t e;
    bit   av;
    av = m_avail();
    if (known) begin
      e.v = av;
      e.f = m_full();
      e.o = m_ovf;
      e.row = '0;
      if (av)
        for (int c = 0; c < COL; c++)
          e.row[c*PB +: PB] = PB'(q[c][0]);
      eq.push_back(e);
    end
    valid = v;
    in    = d;
    rd    = r;
    reset = rst;
    @(posedge clk);
    if (rst) begin
      for (int c = 0; c < COL; c++) q[c].delete();
      m_ovf = 1'b0;
      known = 1'b1;
    end else begin
      for (int c = 0; c < COL; c++) begin
        if (r && av) void'(q[c].pop_front());
        if (v[c]) begin
          if (q[c].size() < DEP) q[c].push_back(int'(d[c*PB +: PB]));
          else m_ovf = 1'b1;
        end
      end
    end
    #1;
  endtask

  function automatic logic [W-1:0] rowval(input int x);
    logic [W-1:0] d;
    for (int c = 0; c < COL; c++) d[c*PB +: PB] = PB'(x);
    return d;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEP && m_avail(); i++)
      step('0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [W-1:0] d;
    checks = 0;
    errors = 0;
    known  = 1'b0;
    m_ovf  = 1'b0;
    valid = '0; in = '0; rd = 1'b0; reset = 1'b1;

    step('0, '0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b1);
    idle(2);

    // Skewed single row: column c written in cycle c.
    for (int c = 0; c < COL; c++) begin
      d = '0;
      d[c*PB +: PB] = PB'(100 + c);
      step(COL'(1) << c, d, 1'b0, 1'b0);
    end
    idle(1);
    step('0, '0, 1'b1, 1'b0);
    idle(1);

    // Fill to full, drop one, then write and pop at full.
    for (int i = 0; i < DEP; i++) step('1, rowval(i), 1'b0, 1'b0);
    step('1, rowval(77), 1'b0, 1'b0);
    step('1, rowval(999), 1'b1, 1'b0);
    drain();
    idle(1);

    // Reset clears the sticky overflow; stream 200 rows.
    step('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 200; i++)
      step('1, rowval(i + 1), m_avail(), 1'b0);
    drain();

    // Randomized traffic at two read rates.
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 500; i++) begin
        for (int c = 0; c < COL; c++)
          d[c*PB +: PB] = PB'($urandom);
        step(COL'($urandom), d,
             ($urandom_range(0, 9) < (ph == 0 ? 2 : 8)), 1'b0);
      end
      drain();
    end

    // Ignored read with column 7 empty, then reset mid-stream.
    step('0, '0, 1'b0, 1'b1);
    step(8'h7f, rowval(5), 1'b0, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    step(8'h80, rowval(6), 1'b0, 1'b0);
    step('1, rowval(7), 1'b1, 1'b1);
    idle(3);

    for (int i = 0; i < 10 && eq.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (eq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", eq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
